// File: rtl/mmio_responder_pkg.sv
// Shared definitions for the MMIO responder: IO page offsets, pin widths, KEY entry layout.
// The timer-related offsets are decoded only when MMIO_TIMER_EN is defined.
package mmio_responder_pkg;

  localparam int SW_W        = 24;
  localparam int BTN_W       = 5;
  localparam int IN_W        = SW_W + BTN_W;

  localparam int KEY_IDX_W     = 3;
  localparam int KEY_VLD_BIT   = 31;
  localparam int KSTAT_CNT_W   = 5;
  localparam int KSTAT_OVF_BIT = 8;

  localparam logic [9:0] ADDR_LED        = 10'h000;
  localparam logic [9:0] ADDR_SEG        = 10'h010;
  localparam logic [9:0] ADDR_SW         = 10'h020;
  localparam logic [9:0] ADDR_KEY        = 10'h030;
  localparam logic [9:0] ADDR_KEY_STAT   = 10'h034;
  localparam logic [9:0] ADDR_TIMER      = 10'h040;
  localparam logic [9:0] ADDR_TIMER_CMP  = 10'h044;
  localparam logic [9:0] ADDR_TIMER_STAT = 10'h048;

  localparam logic [31:0] TIMER_CMP_RST = 32'hFFFF_FFFF;

  typedef logic [KEY_IDX_W-1:0] key_idx_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic key_idx_t lowest_set(input logic [BTN_W-1:0] v);
    lowest_set = '0;
    for (int i = BTN_W - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = key_idx_t'(i);
    end
  endfunction

endpackage

// File: rtl/mmio_responder_if.sv
// CPU-side IO page bus: load/store strobes, byte offset, store data and combinational load data.
// No handshake; a strobe is acted on in the cycle it is high.
interface mmio_responder_if;
  logic        IORead;
  logic        IOWrite;
  logic [9:0]  addr_low;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output IORead, output IOWrite, output addr_low, output wdata, input rdata);
  modport slave  (input IORead, input IOWrite, input addr_low, input wdata, output rdata);
endinterface

// File: rtl/mmio_responder_io_debouncer.sv
// Two-flop synchronizer plus prescaled sampling; a bit follows its input once two consecutive
// samples agree. Latency 2 cycles plus 2-3 prescaler periods; no backpressure.
module io_debouncer #(
  parameter int WIDTH           = 29,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] deb_out
);

  localparam int PW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [WIDTH-1:0] sample_q, sample_d, deb_q, deb_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;
  logic [WIDTH-1:0] agree;

  always_comb begin
    sync1_d  = raw_in;
    sync2_d  = sync1_q;
    tick     = (presc_q == PW'(DEBOUNCE_CYCLES - 1));
    presc_d  = tick ? '0 : presc_q + PW'(1);
    agree    = ~(sync2_q ^ sample_q);
    sample_d = sample_q;
    deb_d    = deb_q;
    if (tick) begin
      sample_d = sync2_q;
      deb_d    = (deb_q & ~agree) | (sync2_q & agree);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      sample_q <= '0;
      deb_q    <= '0;
      presc_q  <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      sample_q <= sample_d;
      deb_q    <= deb_d;
      presc_q  <= presc_d;
    end
  end

  assign deb_out = deb_q;

endmodule

// File: rtl/mmio_responder.sv
// IO page responder: LED/SEG registers, debounced switches, button-event FIFO and (with
// MMIO_TIMER_EN) a compare timer. rdata is combinational; writes/pops take effect next cycle.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int KEY_FIFO_DEPTH  = 4
) (
  input  logic             clock,
  input  logic             reset,
  mmio_responder_if.slave  bus,
  input  logic [SW_W-1:0]  switch_in,
  input  logic [BTN_W-1:0] button_in,
  output logic [23:0]      led_out,
  output logic [31:0]      seg_out,
  output logic             timer_irq
);

  localparam int PTR_W = (KEY_FIFO_DEPTH > 1) ? $clog2(KEY_FIFO_DEPTH) : 1;

  logic [IN_W-1:0]  deb;
  logic [SW_W-1:0]  sw_deb;
  logic [BTN_W-1:0] btn_deb;

  io_debouncer #(
    .WIDTH           (IN_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_io_debouncer (
    .clock   (clock),
    .reset   (reset),
    .raw_in  ({button_in, switch_in}),
    .deb_out (deb)
  );

  assign sw_deb  = deb[SW_W-1:0];
  assign btn_deb = deb[IN_W-1:SW_W];

  // A simultaneous write wins; the read side (KEY pop) is suppressed.
  logic wr_en, rd_en;
  assign wr_en = bus.IOWrite;
  assign rd_en = bus.IORead & ~bus.IOWrite;

  logic [23:0]            led_q, led_d;
  logic [31:0]            seg_q, seg_d;
  logic [BTN_W-1:0]       btn_prev_q, btn_prev_d, pending_q, pending_d;
  key_idx_t               mem_q [KEY_FIFO_DEPTH];
  key_idx_t               mem_d [KEY_FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [KSTAT_CNT_W-1:0] count_q, count_d;
  logic                   ovf_q, ovf_d;

  logic     empty, full, push_req, push, pop, drop;
  key_idx_t push_idx, head;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == KSTAT_CNT_W'(KEY_FIFO_DEPTH));
    head     = mem_q[rd_ptr_q];
    push_req = |pending_q;
    push_idx = lowest_set(pending_q);
    pop      = rd_en && (bus.addr_low == ADDR_KEY) && !empty;
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  always_comb begin
    led_d = led_q;
    seg_d = seg_q;
    if (wr_en && bus.addr_low == ADDR_LED) led_d = bus.wdata[23:0];
    if (wr_en && bus.addr_low == ADDR_SEG) seg_d = bus.wdata;

    // The serviced pending bit clears whether it was queued or dropped.
    btn_prev_d = btn_deb;
    pending_d  = pending_q;
    if (push_req) pending_d[push_idx] = 1'b0;
    pending_d = pending_d | (btn_deb & ~btn_prev_q);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_idx;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop) count_d = count_q + KSTAT_CNT_W'(1);
    else if (pop && !push) count_d = count_q - KSTAT_CNT_W'(1);

    ovf_d = (ovf_q && !(wr_en && bus.addr_low == ADDR_KEY_STAT)) || drop;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_q      <= '0;
      seg_q      <= '0;
      btn_prev_q <= '0;
      pending_q  <= '0;
      for (int i = 0; i < KEY_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      led_q      <= led_d;
      seg_q      <= seg_d;
      btn_prev_q <= btn_prev_d;
      pending_q  <= pending_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] timer_q, timer_d, cmp_q, cmp_d;
  logic        flag_q, flag_d;

  always_comb begin
    timer_d = timer_q + 32'd1;
    cmp_d   = cmp_q;
    if (wr_en && bus.addr_low == ADDR_TIMER)     timer_d = bus.wdata;
    if (wr_en && bus.addr_low == ADDR_TIMER_CMP) cmp_d   = bus.wdata;
    // Compare the value the timer takes at this edge, so the flag rises with the matching count.
    flag_d = (timer_d == cmp_q) || (flag_q && !(wr_en && bus.addr_low == ADDR_TIMER_STAT));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
      cmp_q   <= TIMER_CMP_RST;
      flag_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      cmp_q   <= cmp_d;
      flag_q  <= flag_d;
    end
  end

  assign timer_irq = flag_q;
`else
  assign timer_irq = 1'b0;
`endif

  logic [31:0] rdata_c;

  always_comb begin
    rdata_c = '0;
    case (bus.addr_low)
      ADDR_LED: rdata_c = {8'h00, led_q};
      ADDR_SEG: rdata_c = seg_q;
      ADDR_SW:  rdata_c = {8'h00, sw_deb};
      ADDR_KEY: begin
        if (!empty) begin
          rdata_c[KEY_VLD_BIT]     = 1'b1;
          rdata_c[KEY_IDX_W-1:0]   = head;
        end
      end
      ADDR_KEY_STAT: begin
        rdata_c[KSTAT_CNT_W-1:0] = count_q;
        rdata_c[KSTAT_OVF_BIT]   = ovf_q;
      end
`ifdef MMIO_TIMER_EN
      ADDR_TIMER:      rdata_c = timer_q;
      ADDR_TIMER_CMP:  rdata_c = cmp_q;
      ADDR_TIMER_STAT: rdata_c = {31'd0, flag_q};
`endif
      default: rdata_c = '0;
    endcase
  end

  assign bus.rdata = rdata_c;
  assign led_out   = led_q;
  assign seg_out   = seg_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: register table, debounce glitch, key FIFO order,
// overflow, push/pop while full, timer wrap/match (or its absence without MMIO_TIMER_EN).
module tb_mmio_responder;
  import mmio_responder_pkg::*;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [SW_W-1:0]  switch_in;
  logic [BTN_W-1:0] button_in;
  logic [23:0]      led_out;
  logic [31:0]      seg_out;
  logic             timer_irq;
  int               cyc = 0;
  int               n_checks = 0;
  int               n_fail = 0;

  mmio_responder_if bus();

  mmio_responder #(.DEBOUNCE_CYCLES(4), .KEY_FIFO_DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .switch_in (switch_in),
    .button_in (button_in),
    .led_out   (led_out),
    .seg_out   (seg_out),
    .timer_irq (timer_irq)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // All bus tasks start on a falling edge and return on the next one.
  task automatic idle(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wr(logic [9:0] a, logic [31:0] d);
    bus.IOWrite = 1'b1; bus.addr_low = a; bus.wdata = d;
    @(negedge clock);
    bus.IOWrite = 1'b0;
  endtask

  task automatic rd(logic [9:0] a, output logic [31:0] d);
    bus.IORead = 1'b1; bus.addr_low = a;
    #1 d = bus.rdata;
    @(negedge clock);
    bus.IORead = 1'b0;
  endtask

  task automatic rd_chk(string nm, logic [9:0] a, logic [31:0] e);
    logic [31:0] d;
    rd(a, d);
    check(nm, d, e);
  endtask

  task automatic press(logic [BTN_W-1:0] m);
    button_in = m;
    idle(16);
    button_in = '0;
    idle(16);
  endtask

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] dat;
    logic [31:0] exp;
    logic [23:0] led;
    logic [31:0] seg;
  } vec_t;

  vec_t vt[16];

  initial begin
    logic [31:0] d;
    logic [31:0] cmp_rst;
    int          k;
    bit          found, glitch, seen;

    bus.IORead = 1'b0; bus.IOWrite = 1'b0; bus.addr_low = '0; bus.wdata = '0;
    switch_in = '0; button_in = '0;
`ifdef MMIO_TIMER_EN
    cmp_rst = TIMER_CMP_RST;
`else
    cmp_rst = 32'h0;
`endif

    vt[0]  = '{1'b0, ADDR_LED,        32'h0,         32'h0,         24'h0,      32'h0};
    vt[1]  = '{1'b0, ADDR_SEG,        32'h0,         32'h0,         24'h0,      32'h0};
    vt[2]  = '{1'b0, ADDR_SW,         32'h0,         32'h0,         24'h0,      32'h0};
    vt[3]  = '{1'b0, ADDR_KEY_STAT,   32'h0,         32'h0,         24'h0,      32'h0};
    vt[4]  = '{1'b0, ADDR_TIMER_CMP,  32'h0,         cmp_rst,       24'h0,      32'h0};
    vt[5]  = '{1'b0, ADDR_TIMER_STAT, 32'h0,         32'h0,         24'h0,      32'h0};
    vt[6]  = '{1'b1, ADDR_LED,        32'h00ABCDEF,  32'h0,         24'hABCDEF, 32'h0};
    vt[7]  = '{1'b1, ADDR_SEG,        32'h12345678,  32'h0,         24'hABCDEF, 32'h12345678};
    vt[8]  = '{1'b0, ADDR_LED,        32'h0,         32'h00ABCDEF,  24'hABCDEF, 32'h12345678};
    vt[9]  = '{1'b0, ADDR_SEG,        32'h0,         32'h12345678,  24'hABCDEF, 32'h12345678};
    vt[10] = '{1'b1, 10'h100,         32'hDEADBEEF,  32'h0,         24'hABCDEF, 32'h12345678};
    vt[11] = '{1'b0, 10'h100,         32'h0,         32'h0,         24'hABCDEF, 32'h12345678};
    vt[12] = '{1'b1, ADDR_SW,         32'h00FFFFFF,  32'h0,         24'hABCDEF, 32'h12345678};
    vt[13] = '{1'b0, 10'h004,         32'h0,         32'h0,         24'hABCDEF, 32'h12345678};
    vt[14] = '{1'b1, ADDR_LED,        32'hFF123456,  32'h0,         24'h123456, 32'h12345678};
    vt[15] = '{1'b0, ADDR_LED,        32'h0,         32'h00123456,  24'h123456, 32'h12345678};

    idle(3);
    check("rst_led", {8'h0, led_out}, 32'h0);
    check("rst_seg", seg_out, 32'h0);
    check("rst_irq", {31'h0, timer_irq}, 32'h0);
    reset = 1'b0;
    idle(1);

    for (int i = 0; i < 16; i++) begin
      if (vt[i].wr) wr(vt[i].addr, vt[i].dat);
      else begin
        rd(vt[i].addr, d);
        check($sformatf("vec%0d_rdata", i), d, vt[i].exp);
      end
      check($sformatf("vec%0d_led", i), {8'h0, led_out}, {8'h0, vt[i].led});
      check($sformatf("vec%0d_seg", i), seg_out, vt[i].seg);
    end

    // Switches with a one-cycle glitch on bit 4.
    switch_in = 24'h000005; idle(1);
    switch_in = 24'h000015; idle(1);
    switch_in = 24'h000005;
    bus.addr_low = ADDR_SW;
    glitch = 1'b0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.rdata[4]) glitch = 1'b1;
      if (bus.rdata == 32'h5) seen = 1'b1;
    end
    check("sw_glitch_hidden", {31'h0, glitch}, 32'h0);
    check("sw_settled", {31'h0, seen}, 32'h1);
    rd_chk("sw_read", ADDR_SW, 32'h5);
    switch_in = 24'hA5A5A5; idle(20);
    rd_chk("sw_read2", ADDR_SW, 32'h00A5A5A5);

    // Two presses queued in order; simultaneous read+write must not pop.
    press(5'h08);
    press(5'h02);
    rd_chk("kstat_two", ADDR_KEY_STAT, 32'h2);
    bus.IORead = 1'b1; bus.IOWrite = 1'b1; bus.addr_low = ADDR_KEY; bus.wdata = 32'h0;
    @(negedge clock);
    bus.IORead = 1'b0; bus.IOWrite = 1'b0;
    rd_chk("kstat_no_pop", ADDR_KEY_STAT, 32'h2);
    rd_chk("key_pop3", ADDR_KEY, 32'h80000003);
    rd_chk("key_pop1", ADDR_KEY, 32'h80000001);
    rd_chk("key_empty", ADDR_KEY, 32'h0);
    rd_chk("kstat_zero", ADDR_KEY_STAT, 32'h0);

    // Six events into a depth-4 FIFO.
    press(5'h1F);
    press(5'h01);
    rd_chk("kstat_ovf", ADDR_KEY_STAT, 32'h104);
    wr(ADDR_KEY_STAT, 32'h0);
    rd_chk("kstat_ovf_clr", ADDR_KEY_STAT, 32'h004);

    // Learn the press-to-push delay at a fixed prescaler phase, then pop exactly on a push while full.
    rd_chk("key_pop0", ADDR_KEY, 32'h80000000);
    while (cyc % 4 != 0) @(negedge clock);
    button_in = 5'h10;
    bus.addr_low = ADDR_KEY_STAT;
    found = 1'b0; k = 40;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (!found && bus.rdata[4:0] == 5'd4) begin found = 1'b1; k = i; end
    end
    check("cal_push_seen", {31'h0, found}, 32'h1);
    button_in = '0;
    idle(20);
    rd_chk("kstat_full", ADDR_KEY_STAT, 32'h004);
    while (cyc % 4 != 0) @(negedge clock);
    button_in = 5'h04;
    idle(k - 1);
    rd(ADDR_KEY, d);
    check("pushpop_head", d, 32'h80000001);
    rd_chk("pushpop_kstat", ADDR_KEY_STAT, 32'h004);
    rd_chk("pushpop_q0", ADDR_KEY, 32'h80000002);
    rd_chk("pushpop_q1", ADDR_KEY, 32'h80000003);
    rd_chk("pushpop_q2", ADDR_KEY, 32'h80000004);
    rd_chk("pushpop_tail", ADDR_KEY, 32'h80000002);
    rd_chk("pushpop_empty", ADDR_KEY_STAT, 32'h0);
    button_in = '0;
    idle(20);

`ifdef MMIO_TIMER_EN
    wr(ADDR_TIMER_CMP, 32'h1);
    wr(ADDR_TIMER, 32'hFFFFFFFE);
    rd_chk("tmr_load", ADDR_TIMER, 32'hFFFFFFFE);
    rd_chk("tmr_max", ADDR_TIMER, 32'hFFFFFFFF);
    check("tmr_irq_pre", {31'h0, timer_irq}, 32'h0);
    rd_chk("tmr_wrap", ADDR_TIMER, 32'h0);
    check("tmr_irq_match", {31'h0, timer_irq}, 32'h1);
    rd_chk("tmr_stat_set", ADDR_TIMER_STAT, 32'h1);
    wr(ADDR_TIMER_STAT, 32'h0);
    check("tmr_irq_clr", {31'h0, timer_irq}, 32'h0);
    rd_chk("tmr_stat_clr", ADDR_TIMER_STAT, 32'h0);
`else
    wr(ADDR_TIMER_CMP, 32'h1);
    wr(ADDR_TIMER, 32'hFFFFFFFE);
    rd_chk("notmr_timer", ADDR_TIMER, 32'h0);
    rd_chk("notmr_cmp", ADDR_TIMER_CMP, 32'h0);
    idle(4);
    rd_chk("notmr_stat", ADDR_TIMER_STAT, 32'h0);
    check("notmr_irq", {31'h0, timer_irq}, 32'h0);
`endif

    // Asynchronous reset mid-run.
    bus.addr_low = ADDR_TIMER_CMP;
    reset = 1'b1;
    #1;
    check("midrst_led", {8'h0, led_out}, 32'h0);
    check("midrst_seg", seg_out, 32'h0);
    check("midrst_cmp", bus.rdata, cmp_rst);
    @(negedge clock);
    reset = 1'b0;
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped I/O responder serving the CPU's IO page: acts on the IORead/IOWrite strobes the control decoder raises for lw/sw to the IO region. Holds LED and seven-segment output registers, presents debounced switches, queues debounced button presses in a small FIFO, and provides a free-running timer with compare flag/interrupt. Sits between the CPU data path (ALU result low bits, rt write data) and board pins.

## Interface
- DEBOUNCE_CYCLES, 20000: prescaler period between input samples.
- KEY_FIFO_DEPTH, 4: button-event FIFO entries, power of two, 2..16.
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- IORead  in  1  CPU load to IO page this cycle.
- IOWrite  in  1  CPU store to IO page this cycle.
- addr_low  in  10  byte offset within IO page (ALU result [9:0]).
- wdata  in  32  store data.
- switch_in  in  24  raw board switches, asynchronous.
- button_in  in  5  raw board buttons, asynchronous, active-high.
- rdata  out  32  load data, combinational from current state.
- led_out  out  24  LED register.
- seg_out  out  32  seven-segment data register.
- timer_irq  out  1  timer match flag.

## Operation
- Address map (addr_low): 0x000 LED RW [23:0]; 0x010 SEG RW; 0x020 SW R (debounced); 0x030 KEY R-pop; 0x034 KEY_STAT R, write clears overflow; 0x040 TIMER RW; 0x044 TIMER_CMP RW; 0x048 TIMER_STAT R bit0 = match flag, write clears. Unmapped: rdata = 0, writes ignored. IORead and IOWrite never both high; if both, write is performed, read side effects suppressed.
- Inputs: two-flop synchronizer per bit; prescaler ticks every DEBOUNCE_CYCLES cycles; at each tick synced vector sampled; debounced bit takes sampled value when two consecutive samples agree.
- Button events: debounced rising edge of button i ORs bit i into pending mask. Each cycle lowest set pending bit is pushed (entry = index 0..4) and cleared; if FIFO full and no pop this cycle, entry dropped, overflow sticky set.
- KEY read: rdata[31] = not-empty, rdata[2:0] = head index, else 0; pop at edge if not empty. Read of empty: 0, no state change.
- KEY_STAT: [4:0] count, bit 8 overflow.
- Push and pop same cycle: both happen, count unchanged; allowed when full.
- Timer: 32-bit, +1 per cycle, wraps 0xFFFFFFFF -> 0. Write loads wdata (overrides increment). Match flag sets on edge where TIMER == TIMER_CMP; set wins over simultaneous clear.

## Timing
- Reset values: led_out 0, seg_out 0, timer 0, TIMER_CMP 0xFFFFFFFF, flag/timer_irq 0, debounced 0, pending 0, FIFO empty, overflow 0, prescaler 0.
- Register writes visible at outputs and rdata the cycle after IOWrite.
- rdata combinational, same cycle as IORead; pop effect visible next cycle.
- Input change to debounced: 2 sync cycles plus 2-3 prescaler periods.
- Debounced edge to FIFO entry: 2 cycles (pending, then push) if sole pending bit.
- Reset mid-operation: all state reverts immediately; pending events lost.

## Configuration
- MMIO_TIMER_EN: defined -> timer, compare, flag, timer_irq as above. Undefined -> 0x040-0x048 read 0, writes ignored, timer_irq tied 0, no timer flops.

## Structure
- Shared package: IO page offsets, SW/BTN widths, KEY entry field positions, TIMER_CMP reset value.
- Sub-module io_debouncer (synchronizer, prescaler, sample compare), instantiated once over the 29-bit concatenated {button, switch} vector.

## Test plan
- Reset, write 0x00ABCDEF to 0x000 and 0x12345678 to 0x010 -> led_out 0xABCDEF, seg_out 0x12345678 next cycle; read back equal.
- DEBOUNCE_CYCLES=4, switch_in 0x000005 with 1-cycle glitch on bit 4 -> SW reads 0x000005, glitch never appears.
- Press buttons 3 then 1 -> KEY reads 0x80000003, 0x80000001, then 0; KEY_STAT count 2 -> 0.
- Six presses, no reads, depth 4 -> count 4, overflow 1; write 0x034 -> overflow 0, count 4.
- Pop while push in same cycle with FIFO full -> count stays 4, no overflow, new entry at tail.
- Write TIMER 0xFFFFFFFE, CMP 0x00000001 -> wraps through 0, flag and timer_irq high 3 cycles after load; write 0x048 clears; undefined MMIO_TIMER_EN -> reads 0, irq 0.
